// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus responder: register map, STATUS layout,
// UART TX states and the address-decode target type.
package dbus_pkg;

  localparam logic [31:0] TXDATA_OFS = 32'h0;
  localparam logic [31:0] STATUS_OFS = 32'h4;
  localparam logic [31:0] BAUD_OFS   = 32'h8;

  localparam int ST_FULL_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_BUSY_BIT  = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_CNT_LSB   = 4;
  localparam int ST_CNT_MSB   = 6;
  localparam int ST_PAR_BIT   = 7;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_MMIO,
    TGT_NONE
  } tgt_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/uart_tx_core.sv
// UART transmitter: TX FIFO, programmable baud divider and framing FSM.
// DBUS_UART_PARITY_EN inserts an even-parity bit between the data and stop bits.
module uart_tx_core
  import dbus_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [7:0]                   push_data,
  input  logic                         baud_wr,
  input  logic [15:0]                  baud_wdata,
  input  logic                         clr_ovf,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         busy,
  output logic                         overflow,
  output logic [15:0]                  baud_div,
  output logic                         tx
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          pop, push_ok, bit_end;
  tx_state_t     state, state_n;
  logic [15:0]   bcnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  assign full    = count == (PW+1)'(FIFO_DEPTH);
  assign empty   = count == '0;
  assign pop     = (state == TX_IDLE) && !empty;
  // a pop in the same cycle frees the slot a push to a full FIFO needs
  assign push_ok = push && (!full || pop);
  assign bit_end = bcnt == 16'd1;

  always_ff @(posedge clk)
    if (push_ok) fifo[wr_ptr] <= push_data;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
      else if (clr_ovf)     overflow <= 1'b0;
    end

  always_ff @(posedge clk or posedge reset)
    if (reset)        baud_div <= 16'(CLKS_PER_BIT);
    else if (baud_wr) baud_div <= (baud_wdata == '0) ? 16'd1 : baud_wdata;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= TX_IDLE;
    else       state <= state_n;

  // bcnt reloads from baud_div only at bit boundaries, so BAUD writes land there
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      shift   <= '0;
      bit_idx <= '0;
      bcnt    <= 16'(CLKS_PER_BIT);
    end else if (pop) begin
      shift   <= fifo[rd_ptr];
      bit_idx <= '0;
      bcnt    <= baud_div;
    end else if (state != TX_IDLE) begin
      if (bit_end) begin
        bcnt <= baud_div;
        if (state == TX_DATA) bit_idx <= bit_idx + 1'b1;
      end else begin
        bcnt <= bcnt - 1'b1;
      end
    end

  always_comb begin
    state_n = state;
    case (state)
      TX_IDLE:   if (!empty) state_n = TX_START;
      TX_START:  if (bit_end) state_n = TX_DATA;
      TX_DATA:
        if (bit_end && bit_idx == 3'd7) begin
`ifdef DBUS_UART_PARITY_EN
          state_n = TX_PARITY;
`else
          state_n = TX_STOP;
`endif
        end
      TX_PARITY: if (bit_end) state_n = TX_STOP;
      TX_STOP:   if (bit_end) state_n = TX_IDLE;
      default:   state_n = TX_IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = state != TX_IDLE;
    case (state)
      TX_START:  tx = 1'b0;
      TX_DATA:   tx = shift[bit_idx];
      TX_PARITY: tx = ^shift;
      default:   tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data-memory responder for the single-cycle core: address decode, word RAM,
// UART register block and sticky bus-error flag. Honours DBUS_UART_PARITY_EN.
module data_bus_responder
  import dbus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE     = 32'h1001_0000,
  parameter int          MEM_DEPTH    = 64,
  parameter logic [31:0] MMIO_BASE    = 32'h1001_0800,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] data_address,
  input  logic [31:0] writedata,
  output logic [31:0] read_data,
  output logic        uart_tx,
  output logic        bus_error
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH);

  bus_req_t      req;
  tgt_t          tgt;
  logic [31:0]   ram_ofs;
  logic [AW-1:0] ram_idx;
  logic          is_txdata, is_status, is_baud;
  logic [31:0]   ram [MEM_DEPTH];
  logic [31:0]   status;

  logic          fifo_full, fifo_empty, tx_busy, ovf;
  logic [CW:0]   fifo_count;
  logic [15:0]   baud_div;

  assign req     = '{rd: memread, wr: memwrite, addr: data_address, wdata: writedata};
  // addresses below RAM_BASE wrap to large offsets, so one compare bounds both ends
  assign ram_ofs = req.addr - RAM_BASE;
  assign ram_idx = ram_ofs[AW+1:2];

  always_comb begin
    tgt       = TGT_NONE;
    is_txdata = 1'b0;
    is_status = 1'b0;
    is_baud   = 1'b0;
    if (req.addr[1:0] == 2'b00) begin
      if (ram_ofs < 32'(4*MEM_DEPTH)) begin
        tgt = TGT_RAM;
      end else begin
        is_txdata = req.addr == MMIO_BASE + TXDATA_OFS;
        is_status = req.addr == MMIO_BASE + STATUS_OFS;
        is_baud   = req.addr == MMIO_BASE + BAUD_OFS;
        if (is_txdata || is_status || is_baud) tgt = TGT_MMIO;
      end
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset)                                      bus_error <= 1'b0;
    else if ((req.rd || req.wr) && tgt == TGT_NONE) bus_error <= 1'b1;

  always_ff @(posedge clk)
    if (req.wr && tgt == TGT_RAM) ram[ram_idx] <= req.wdata;

  uart_tx_core #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk       (clk),
    .reset     (reset),
    .push      (req.wr && is_txdata),
    .push_data (req.wdata[7:0]),
    .baud_wr   (req.wr && is_baud),
    .baud_wdata(req.wdata[15:0]),
    .clr_ovf   (req.wr && is_status),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .busy      (tx_busy),
    .overflow  (ovf),
    .baud_div  (baud_div),
    .tx        (uart_tx)
  );

  always_comb begin
    status                        = '0;
    status[ST_FULL_BIT]           = fifo_full;
    status[ST_EMPTY_BIT]          = fifo_empty;
    status[ST_BUSY_BIT]           = tx_busy;
    status[ST_OVF_BIT]            = ovf;
    status[ST_CNT_MSB:ST_CNT_LSB] = 3'(fifo_count);
`ifdef DBUS_UART_PARITY_EN
    status[ST_PAR_BIT]            = 1'b1;
`endif
  end

  always_comb begin
    read_data = '0;
    if (req.rd) begin
      case (tgt)
        TGT_RAM:  read_data = ram[ram_idx];
        TGT_MMIO: read_data = is_status ? status :
                              is_baud   ? {16'h0, baud_div} : 32'h0;
        default:  read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: directed steps plus random RAM
// traffic and random UART frames checked against a behavioural model.
module tb_data_bus_responder;
  localparam logic [31:0] RAM_BASE  = 32'h1001_0000;
  localparam logic [31:0] MMIO_BASE = 32'h1001_0800;
  localparam logic [31:0] A_TXDATA  = MMIO_BASE + 32'h0;
  localparam logic [31:0] A_STATUS  = MMIO_BASE + 32'h4;
  localparam logic [31:0] A_BAUD    = MMIO_BASE + 32'h8;
  localparam int          DEPTH     = 64;
  localparam int          FD        = 4;
`ifdef DBUS_UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 10 + PAR;

  logic        clk = 1'b0, reset = 1'b1;
  logic        memwrite = 1'b0, memread = 1'b0;
  logic [31:0] data_address = '0, writedata = '0;
  logic [31:0] read_data;
  logic        uart_tx, bus_error;

  int ncmp = 0, nbad = 0;
  logic [31:0] model [DEPTH];
  bit          valid [DEPTH];

  data_bus_responder dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
    .data_address(data_address), .writedata(writedata),
    .read_data(read_data), .uart_tx(uart_tx), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; data_address = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    memread = 1'b1; data_address = a;
    #1 d = read_data;
    tick();
    memread = 1'b0;
  endtask

  function automatic logic [31:0] exp_status(int cnt, bit busy, bit ovf);
    return 32'((cnt == FD) | ((cnt == 0) << 1) | (busy << 2) | (ovf << 3) | (cnt << 4) | (PAR << 7));
  endfunction

  // Sends one byte from idle and checks tx/busy/empty every cycle against the
  // frame built from the bit list: start, 8 data LSB first, [parity], stop.
  task automatic send_check(input logic [7:0] b, input int baud);
    bit frame[$];
    logic [31:0] st;
    bit exp_tx, in_frame;
    frame.push_back(1'b0);
    for (int i = 0; i < 8; i++) frame.push_back(b[i]);
    if (PAR != 0) frame.push_back(^b);
    frame.push_back(1'b1);
    wr(A_BAUD, 32'(baud));
    wr(A_TXDATA, {24'h0, b});
    for (int k = 0; k <= NB*baud + 1; k++) begin
      memread = 1'b1; data_address = A_STATUS;
      #1 st = read_data;
      in_frame = (k >= 1) && (k <= NB*baud);
      exp_tx   = in_frame ? frame[(k-1)/baud] : 1'b1;
      chk("frame_tx", 32'(uart_tx), 32'(exp_tx));
      chk("frame_busy", 32'(st[2]), 32'(in_frame));
      chk("frame_empty", 32'(st[1]), 32'(k >= 1));
      tick();
    end
    memread = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int idx, q;

    // reset state, released between clock edges
    #12 reset = 1'b0;
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_buserr", 32'(bus_error), 32'd0);
    rd(A_STATUS, d); chk("rst_status", d, exp_status(0, 0, 0));
    rd(A_BAUD, d);   chk("rst_baud", d, 32'd16);
    rd(A_TXDATA, d); chk("txdata_rd0", d, 32'd0);
    memread = 1'b0; data_address = A_STATUS; #1;
    chk("rd_gated", read_data, 32'd0);

    // directed RAM
    wr(RAM_BASE + 32'h4, 32'hDEAD_BEEF); model[1] = 32'hDEAD_BEEF; valid[1] = 1;
    wr(RAM_BASE + 32'h8, 32'h1234_5678); model[2] = 32'h1234_5678; valid[2] = 1;
    rd(RAM_BASE + 32'h4, d); chk("ram_w1", d, 32'hDEAD_BEEF);
    rd(RAM_BASE + 32'h8, d); chk("ram_w2", d, 32'h1234_5678);
    wr(RAM_BASE, 32'hCAFE_0000); model[0] = 32'hCAFE_0000; valid[0] = 1;
    wr(RAM_BASE + 32'(4*(DEPTH-1)), 32'h0BAD_F00D); model[DEPTH-1] = 32'h0BAD_F00D; valid[DEPTH-1] = 1;
    rd(RAM_BASE + 32'(4*(DEPTH-1)), d); chk("ram_top", d, 32'h0BAD_F00D);

    // random RAM traffic against the model
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, DEPTH-1);
      if (valid[idx] && ($urandom_range(0, 1) == 1)) begin
        rd(RAM_BASE + 32'(4*idx), d); chk("ram_rand", d, model[idx]);
      end else begin
        d = $urandom;
        wr(RAM_BASE + 32'(4*idx), d); model[idx] = d; valid[idx] = 1;
      end
    end

    // read and write together: read shows pre-write value
    memread = 1'b1; memwrite = 1'b1; data_address = RAM_BASE + 32'h8; writedata = 32'h5555_AAAA;
    #1 chk("rdwr_old", read_data, model[2]);
    tick(); memread = 1'b0; memwrite = 1'b0; model[2] = 32'h5555_AAAA;
    rd(RAM_BASE + 32'h8, d); chk("rdwr_new", d, 32'h5555_AAAA);
    chk("ram_no_err", 32'(bus_error), 32'd0);

    // BAUD write of 0 stores 1
    wr(A_BAUD, 32'h0);       rd(A_BAUD, d); chk("baud_zero", d, 32'd1);
    wr(A_BAUD, 32'hABCD_0123); rd(A_BAUD, d); chk("baud_16b", d, 32'h0123);

    // frame timing
    send_check(8'hA5, 4);
    for (int n = 0; n < 4; n++) send_check(8'($urandom_range(0, 255)), $urandom_range(1, 5));
    send_check(8'h07, 3);

    // overflow: the first byte is popped, FD are queued, the rest drop
    wr(A_BAUD, 32'd100);
    memwrite = 1'b1; data_address = A_TXDATA;
    for (int i = 0; i < 6; i++) begin writedata = 32'(8'h30 + i); tick(); end
    memwrite = 1'b0;
    q = 6 - 1;
    rd(A_STATUS, d); chk("ovf_status", d, exp_status((q > FD) ? FD : q, 1, q > FD));
    wr(A_STATUS, 32'h0);
    rd(A_STATUS, d); chk("ovf_clear", d, exp_status((q > FD) ? FD : q, 1, 0));
    chk("ovf_no_err", 32'(bus_error), 32'd0);

    // bus errors
    rd(32'h2000_0000, d); chk("unmapped_rd", d, 32'd0);
    chk("buserr_set", 32'(bus_error), 32'd1);
    rd(MMIO_BASE + 32'hC, d); chk("mmio_hole_rd", d, 32'd0);
    rd(RAM_BASE + 32'h1, d);  chk("misalign_rd", d, 32'd0);
    wr(RAM_BASE + 32'h2, 32'hFFFF_FFFF);
    rd(RAM_BASE, d); chk("misalign_wr_drop", d, model[0]);
    repeat (5) tick();
    chk("buserr_sticky", 32'(bus_error), 32'd1);

    // reset mid-frame during data bit 3 of 0x00
    reset = 1'b1; #2 reset = 1'b0;
    wr(A_BAUD, 32'd4);
    wr(A_TXDATA, 32'h00);
    repeat (18) tick();
    chk("mid_bit3_low", 32'(uart_tx), 32'd0);
    reset = 1'b1;
    #1 chk("rst_async_tx", 32'(uart_tx), 32'd1);
    chk("rst_async_err", 32'(bus_error), 32'd0);
    #2 reset = 1'b0;
    rd(A_STATUS, d); chk("post_rst_status", d, exp_status(0, 0, 0));
    rd(A_BAUD, d);   chk("post_rst_baud", d, 32'd16);
    chk("par_flag", 32'(d[7]), 32'd0);
    rd(A_STATUS, d); chk("status_bit7", 32'(d[7]), 32'(PAR));
    repeat (20) tick();
    chk("post_rst_idle", 32'(uart_tx), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
